// File: rtl/adder_pkg.sv
// Shared widths, FSM state type and expected-sum helper for the adder BIST.
package adder_pkg;

    localparam int OP_W  = 4;
    localparam int SUM_W = 5;
    localparam int IDX_W = 9;
    localparam int ERR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_e;

    // Vector index layout is {c0, B, A}; bit 4 of the result is the carry-out.
    function automatic logic [SUM_W-1:0] expected_sum(input logic [IDX_W-1:0] v);
        return {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'b0000, v[8]};
    endfunction

endpackage

// File: rtl/bist_expect_pipe.sv
// Delay line carrying expected sum, valid bit and vector index so each
// expectation meets the adder result it belongs to.
module bist_expect_pipe #(
    parameter int DEPTH = 3,
    parameter int DW    = 5,
    parameter int IW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_exp,
    input  logic [IW-1:0] i_idx,
    output logic          o_valid,
    output logic [DW-1:0] o_exp,
    output logic [IW-1:0] o_idx
);

    logic          r_valid [DEPTH];
    logic [DW-1:0] r_exp   [DEPTH];
    logic [IW-1:0] r_idx   [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_exp[i]   <= '0;
                r_idx[i]   <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_exp[0]   <= i_exp;
            r_idx[0]   <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_exp[i]   <= r_exp[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_exp   = r_exp[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/adder_bist.sv
// BIST controller: sweeps every {c0,B,A} vector into the pipelined adder and
// checks each registered sum against a delayed expected value.
module adder_bist
    import adder_pkg::*;
#(
    parameter int VECTORS = 512,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vdd,
    input  logic              gnd,
    input  logic              start,
    output logic [OP_W-1:0]   A_o,
    output logic [OP_W-1:0]   B_o,
    output logic              c0_o,
    input  logic [SUM_W-1:0]  S_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [IDX_W-1:0]  first_fail_vec,
    output bist_state_e       o_dbg_state
);

    localparam logic [IDX_W:0]   N_VEC    = (IDX_W+1)'(VECTORS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    bist_state_e      r_state, w_state_next;
    logic [IDX_W:0]   r_vec;
    logic [OP_W-1:0]  r_a, r_b;
    logic             r_c0_pend, r_c0;
    logic [ERR_W-1:0] r_err;
    logic [IDX_W-1:0] r_first;

    logic             w_issue, w_clear, w_last_cmp, w_mismatch;
    logic [IDX_W-1:0] w_issue_idx;
    logic             w_pipe_valid;
    logic [SUM_W-1:0] w_pipe_exp;
    logic [IDX_W-1:0] w_pipe_idx;
    logic             w_unused;

    assign w_unused = vdd ^ gnd;

    bist_expect_pipe #(
        .DEPTH (LATENCY + 1),
        .DW    (SUM_W),
        .IW    (IDX_W)
    ) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_issue),
        .i_exp   (expected_sum(w_issue_idx)),
        .i_idx   (w_issue_idx),
        .o_valid (w_pipe_valid),
        .o_exp   (w_pipe_exp),
        .o_idx   (w_pipe_idx)
    );

    assign w_last_cmp = w_pipe_valid && (w_pipe_idx == LAST_IDX);
    assign w_mismatch = w_pipe_valid && (S_i != w_pipe_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_idx  = '0;
        w_clear      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_issue      = 1'b1;
                    w_clear      = 1'b1;
                end
            end
            RUN: begin
                if (r_vec < N_VEC) begin
                    w_issue     = 1'b1;
                    w_issue_idx = r_vec[IDX_W-1:0];
                end else if (w_last_cmp) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_last_cmp) w_state_next = DONE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // c0 lags A/B by one edge to line up with the adder's internal A/B registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c0_pend <= 1'b0;
            r_c0      <= 1'b0;
        end else begin
            r_c0 <= r_c0_pend;
            if (w_issue) begin
                r_vec     <= {1'b0, w_issue_idx} + 1'b1;
                r_a       <= w_issue_idx[3:0];
                r_b       <= w_issue_idx[7:4];
                r_c0_pend <= w_issue_idx[8];
            end else begin
                r_a       <= '0;
                r_b       <= '0;
                r_c0_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err   <= '0;
            r_first <= '0;
        end else if (w_clear) begin
            r_err   <= '0;
            r_first <= '0;
        end else if (w_mismatch) begin
            if (r_err != ERR_MAX) r_err <= r_err + 1'b1;
            if (r_err == '0)      r_first <= w_pipe_idx;
        end
    end

    assign A_o            = r_a;
    assign B_o            = r_b;
    assign c0_o           = r_c0;
    assign busy           = (r_state == RUN) || (r_state == DRAIN);
    assign done           = (r_state == DONE);
    assign pass           = done && (r_err == '0);
    assign err_count      = r_err;
    assign first_fail_vec = r_first;
    assign o_dbg_state    = r_state;

endmodule
